// File: rtl/ccsds123_out_byte_serializer.sv
// Serializes BUS_WIDTH-wide AXI4-Stream words into byte beats, byte 0 first.
// Optional statistics counters are built when CCSDS123_BYTE_SER_STATS_EN is defined.
module ccsds123_out_byte_serializer #(
    parameter int BUS_WIDTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [BUS_WIDTH-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [CNT_W-1:0]     stat_words,
    output logic [CNT_W-1:0]     stat_bytes,
    output logic [CNT_W-1:0]     stat_stalls
);

    localparam int NB = BUS_WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic {
        EMPTY,
        EMIT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [BUS_WIDTH-1:0] hold_data;
    logic                 hold_last;
    logic                 hold_valid;
    logic                 rdy_en;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        idx_d;
    logic                 at_last;
    logic                 last_beat;
    logic                 accept;
    logic                 load;

    assign hold_valid = (state_q == EMIT);
    assign at_last    = (idx_q == LAST_IDX);
    assign last_beat  = hold_valid & m_axis_tready & at_last;

    // rdy_en keeps tready low while in reset and rises on the first edge after
    assign s_axis_tready = rdy_en & (!hold_valid | last_beat);
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = 8'(hold_data >> {idx_q, 3'b000});
    assign m_axis_tvalid = hold_valid;
    assign m_axis_tlast  = hold_valid & hold_last & at_last;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = EMIT;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    if (!at_last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (accept) begin
                        idx_d = '0;
                        load  = 1'b1;
                    end else begin
                        state_d = EMPTY;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= EMPTY;
            idx_q     <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rdy_en  <= 1'b1;
            if (load) begin
                hold_data <= s_axis_tdata;
                hold_last <= s_axis_tlast;
            end
        end
    end

`ifdef CCSDS123_BYTE_SER_STATS_EN
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic byte_hs;
    logic stall;

    assign byte_hs = hold_valid & m_axis_tready;
    assign stall   = hold_valid & !m_axis_tready;

    // all counters saturate instead of wrapping
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stat_words  <= '0;
            stat_bytes  <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept && stat_words != CMAX) begin
                stat_words <= stat_words + 1'b1;
            end
            if (byte_hs && stat_bytes != CMAX) begin
                stat_bytes <= stat_bytes + 1'b1;
            end
            if (stall && stat_stalls != CMAX) begin
                stat_stalls <= stat_stalls + 1'b1;
            end
        end
    end
`else
    assign stat_words  = '0;
    assign stat_bytes  = '0;
    assign stat_stalls = '0;
`endif

endmodule
